// File: rtl/apb_bram_ctrl.sv
// APB slave that owns BRAM port A. It turns bus reads and writes into single-cycle port-A operations
// and runs a built-in engine that fills the whole memory with a constant.
module apb_bram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  input  logic                  clear_req_i,
  output logic                  clear_busy_o,
  output logic [ADDR_WIDTH-1:0] bram_addra_o,
  output logic                  bram_wea_o,
  output logic [DATA_WIDTH-1:0] bram_dina_o,
  input  logic [DATA_WIDTH-1:0] bram_douta_i
);

  typedef enum logic [2:0] {StIdle, StAcc, StRd, StResp, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  wea_q, wea_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  busy_q, busy_d;
  logic                  pend_q, pend_d;

  logic [ADDR_WIDTH-1:0] word;
  logic                  acc_err;
  logic                  unused_inputs;

  assign word    = paddr_i[ADDR_WIDTH+1:2];
  assign acc_err = (paddr_i[1:0] != 2'b00) || (paddr_i[31:ADDR_WIDTH+2] != '0);

  // penable_i is ignored so that stalled transfers are still taken from IDLE
  assign unused_inputs = penable_i ^ (^pwdata_i);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    prdata_d  = prdata_q;
    wea_d     = 1'b0;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    busy_d    = 1'b0;
    pend_d    = pend_q;

    if (clear_req_i && (state_q != StClear)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Clear takes priority: its duration is bounded, a stalled bus transfer is not
        if (pend_q || clear_req_i) begin
          state_d = StClear;
          pend_d  = 1'b0;
          addr_d  = '0;
          din_d   = CLEAR_VALUE;
          wea_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (psel_i) begin
          state_d = StAcc;
          addr_d  = word;
          din_d   = pwdata_i[DATA_WIDTH-1:0];
          wea_d   = pwrite_i & ~acc_err;
          err_d   = acc_err;
        end
      end
      StAcc: begin
        if (!wea_q && !err_q) begin
          state_d = StRd;
        end else begin
          state_d   = StResp;
          pready_d  = 1'b1;
          pslverr_d = err_q;
        end
      end
      StRd: begin
        prdata_d  = bram_douta_i;
        state_d   = StResp;
        pready_d  = 1'b1;
        pslverr_d = err_q;
      end
      StResp: begin
        state_d = StIdle;
      end
      StClear: begin
        if (addr_q == '1) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          wea_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      din_q     <= '0;
      prdata_q  <= '0;
      wea_q     <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      prdata_q  <= prdata_d;
      wea_q     <= wea_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
    end
  end

  assign prdata_o     = 32'(prdata_q);
  assign pready_o     = pready_q;
  assign pslverr_o    = pslverr_q;
  assign clear_busy_o = busy_q;
  assign bram_addra_o = addr_q;
  assign bram_wea_o   = wea_q;
  assign bram_dina_o  = din_q;

endmodule

// File: tb/tb_apb_bram_ctrl.sv
// Bench for apb_bram_ctrl: a behavioural BRAM on port A, plus a word-array reference model
// that predicts read data, error responses and response latency for each transfer.
module tb_apb_bram_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam logic [7:0]  CV = 8'h20;
  localparam int unsigned NWORDS = 16;

  logic        clk, rst_n;
  logic        psel, penable, pwrite, clear_req;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr, busy;
  logic [3:0]  bram_addr;
  logic        bram_we;
  logic [7:0]  bram_din, bram_dout;

  apb_bram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .clear_req_i (clear_req),
    .clear_busy_o(busy),
    .bram_addra_o(bram_addr),
    .bram_wea_o  (bram_we),
    .bram_dina_o (bram_din),
    .bram_douta_i(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous BRAM port A
  logic [7:0] bram [NWORDS];
  always @(posedge clk) begin
    if (bram_we) bram[bram_addr] <= bram_din;
    bram_dout <= bram[bram_addr];
  end

  logic [7:0]  ref_mem [NWORDS];
  logic [31:0] ref_prdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Results of the last transfer, as observed on the pins
  int          o_lat, o_last_busy, o_busy_cnt, o_wea_cnt, o_wea_idx, o_pready_busy;
  logic [3:0]  o_wea_addr;
  logic [7:0]  o_wea_din;
  logic [31:0] o_rdata;
  logic        o_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // clr_at: sample index whose cycle also drives clear_req high (-1 for never)
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int clr_at);
    bit done = 0;
    o_lat = -1; o_last_busy = -1; o_busy_cnt = 0; o_wea_cnt = 0; o_wea_idx = -1;
    o_pready_busy = 0; o_rdata = 'x; o_err = 1'bx; o_wea_addr = 'x; o_wea_din = 'x;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    clear_req = (clr_at == 0);
    for (int idx = 0; idx < 64 && !done; idx++) begin
      @(negedge clk);
      if (busy) begin o_busy_cnt++; o_last_busy = idx; end
      if (bram_we && !busy) begin
        o_wea_cnt++; o_wea_idx = idx; o_wea_addr = bram_addr; o_wea_din = bram_din;
      end
      if (pready && busy) o_pready_busy++;
      if (pready) begin o_lat = idx; o_rdata = prdata; o_err = pslverr; done = 1; end
      @(posedge clk); #1;
      if (!done) begin penable = 1'b1; clear_req = (idx + 1 == clr_at); end
    end
    psel = 1'b0; penable = 1'b0; clear_req = 1'b0;
  endtask

  // Predict the transfer from the address rules and the reference memory, then update the model
  task automatic check_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    logic       exp_err;
    logic [3:0] w;
    int         t0;
    exp_err = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
    w       = addr[AW+1:2];
    t0      = o_last_busy + 1;
    check_eq({tag, "_lat"}, o_lat, t0 + ((wr || exp_err) ? 2 : 3));
    check_eq({tag, "_err"}, o_err, exp_err);
    check_eq({tag, "_wecnt"}, o_wea_cnt, (wr && !exp_err) ? 1 : 0);
    check_eq({tag, "_rdybusy"}, o_pready_busy, 0);
    if (wr && !exp_err) begin
      check_eq({tag, "_weidx"}, o_wea_idx, t0 + 1);
      check_eq({tag, "_weaddr"}, o_wea_addr, w);
      check_eq({tag, "_wedin"}, o_wea_din, wdata[7:0]);
      ref_mem[w] = wdata[7:0];
    end
    if (!wr && !exp_err) ref_prdata = {24'h0, ref_mem[w]};
    check_eq({tag, "_rdata"}, o_rdata, ref_prdata);
  endtask

  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    apb_xfer(wr, addr, wdata, -1);
    check_xfer(tag, wr, addr, wdata);
  endtask

  // Watch one full clear: busy count, address sequence, write strobe and fill value
  task automatic do_clear(input string tag, input logic pulse);
    int n = 0;
    int bad = 0;
    bit seen_end = 0;
    clear_req = pulse;
    for (int i = 0; i < 60 && !seen_end; i++) begin
      @(negedge clk);
      if (busy) begin
        if (bram_addr !== 4'(n) || bram_we !== 1'b1 || bram_din !== CV) bad++;
        n++;
      end else if (n > 0) begin
        seen_end = 1;
      end
      @(posedge clk); #1;
      clear_req = 1'b0;
    end
    check_eq({tag, "_busycnt"}, n, NWORDS);
    check_eq({tag, "_seqbad"}, bad, 0);
    for (int k = 0; k < NWORDS; k++) ref_mem[k] = CV;
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < NWORDS; k++) do_xfer($sformatf("%s%0d", tag, k), 1'b0, k * 4, 0);
  endtask

  initial begin
    int  cnt;
    bit  found;
    logic [31:0] a, d;
    logic        wr;

    for (int k = 0; k < NWORDS; k++) ref_mem[k] = 8'h00;
    ref_prdata = 32'h0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; clear_req = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_prdata", prdata, 32'h0);
    check_eq("rst_ctl", {pready, pslverr, busy, bram_addr, bram_we, bram_din}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_xfer("wr_a5", 1'b1, 32'h8, 32'hFFFF_FFA5);
    do_xfer("rd_a5", 1'b0, 32'h8, 0);
    do_xfer("err_mis_wr", 1'b1, 32'h41, 32'h33);
    do_xfer("err_mis_rd", 1'b0, 32'h41, 0);
    do_xfer("err_oor_wr", 1'b1, 32'h40, 32'h44);
    do_xfer("err_oor_rd", 1'b0, 32'h40, 0);

    do_clear("clr", 1'b1);
    read_all("clr_rd");

    // Write arriving while a clear is already at word 3
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < NWORDS; k++) ref_mem[k] = CV;
    apb_xfer(1'b1, 32'hC, 32'h5A, -1);
    check_xfer("ovl_wr", 1'b1, 32'hC, 32'h5A);
    check_eq("ovl_busycnt", o_busy_cnt, 13);
    do_xfer("ovl_rd", 1'b0, 32'hC, 0);

    // psel and clear_req together: clear first, then the write
    do_xfer("pre_wr", 1'b1, 32'h0, 32'h11);
    for (int k = 0; k < NWORDS; k++) ref_mem[k] = CV;
    apb_xfer(1'b1, 32'h14, 32'h77, 0);
    check_xfer("tie_wr", 1'b1, 32'h14, 32'h77);
    check_eq("tie_busycnt", o_busy_cnt, NWORDS);
    do_xfer("tie_rd5", 1'b0, 32'h14, 0);
    do_xfer("tie_rd0", 1'b0, 32'h0, 0);

    // Clear requested during ACC of a read
    do_xfer("acc_wr", 1'b1, 32'h24, 32'h3C);
    apb_xfer(1'b0, 32'h24, 0, 1);
    check_xfer("acc_rd", 1'b0, 32'h24, 0);
    check_eq("acc_busycnt", o_busy_cnt, 0);
    do_clear("acc_clr", 1'b0);
    do_xfer("acc_rd2", 1'b0, 32'h24, 0);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      case ($urandom_range(0, 9))
        7:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8:       a = $urandom | 32'h40;
        9:       a = 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      do_xfer($sformatf("rnd%0d", i), wr, a, d);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a clear
    for (int k = 0; k < NWORDS; k++) do_xfer($sformatf("fill%0d", k), 1'b1, k * 4, 8'h80 + k);
    do_xfer("fill_rd", 1'b0, 32'h4, 0);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy && bram_addr == 4'd7) found = 1;
    end
    check_eq("mid_found", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_prdata", prdata, 32'h0);
    check_eq("mid_ctl", {pready, pslverr, busy, bram_addr, bram_we, bram_din}, 16'h0);
    for (int k = 0; k < 7; k++) ref_mem[k] = CV;
    ref_prdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (busy || bram_we) cnt++;
    end
    check_eq("mid_norestart", cnt, 0);
    @(posedge clk); #1;
    read_all("mid_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_bram_ctrl.md
# apb_bram_ctrl

APB slave controller that owns port A of the character/attribute dual-port BRAM and sequences all accesses to it. It converts APB reads and writes into single-cycle BRAM port-A operations with wait states that absorb the one-cycle read latency. A built-in clear engine fills the whole memory with a constant and shares port A with the bus. Port B stays with the VGA scanout path and is untouched by this block.

## Interface
- `ADDR_WIDTH`, default 4: BRAM word-address width; depth is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: BRAM word width, ≤ 32.
- `CLEAR_VALUE`, default 0: DATA_WIDTH-bit word written by the clear engine.

Ports:
- `clk_i` in 1: single clock; BRAM and APB share this clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable.
- `pwrite_i` in 1: APB direction; 1 = write.
- `paddr_i` in 32: APB byte address.
- `pwdata_i` in 32: APB write data; bits above DATA_WIDTH are ignored.
- `prdata_o` out 32: read data, zero-extended BRAM word.
- `pready_o` out 1: transfer complete.
- `pslverr_o` out 1: error response, valid while pready_o is high.
- `clear_req_i` in 1: request a full-memory clear (pulse or level).
- `clear_busy_o` out 1: clear in progress.
- `bram_addra_o` out ADDR_WIDTH: BRAM port-A address.
- `bram_wea_o` out 1: BRAM port-A write enable.
- `bram_dina_o` out DATA_WIDTH: BRAM port-A write data.
- `bram_douta_i` in DATA_WIDTH: BRAM port-A read data, valid one cycle after its address.

## Operation
- **Reset:** every output is 0, state is IDLE, clear_pending is 0. Reset mid-operation aborts immediately; a partially cleared memory stays partially cleared.
- **Address decode:** word = paddr_i[ADDR_WIDTH+1:2]. An access is an error if paddr_i[1:0] != 0 or paddr_i[31:ADDR_WIDTH+2] != 0.
- **clear_pending:** set on any cycle where clear_req_i=1 and the state is not CLEAR. Cleared on entry to CLEAR. A request made during CLEAR is dropped.
- **FSM states:**
  - IDLE: if clear_pending or clear_req_i is set, go to CLEAR; clear wins over APB because its duration is bounded. Otherwise, if psel_i=1 (penable_i value ignored, so stalled transfers are taken), latch bram_addra_o←word, bram_dina_o←pwdata_i[DATA_WIDTH-1:0], bram_wea_o←pwrite_i & !error, err←error, and go to ACC.
  - ACC: the BRAM sees addr/wea for this single cycle; wea drops after it. Go to RD for a valid read, otherwise to RESP.
  - RD: bram_douta_i is valid; capture it into prdata_o, then go to RESP.
  - RESP: pready_o=1 and pslverr_o=err for exactly one cycle, then go to IDLE.
  - CLEAR: bram_wea_o=1, bram_dina_o=CLEAR_VALUE, bram_addra_o counts 0 → 2**ADDR_WIDTH−1, one word per cycle. After the last word go to IDLE. clear_busy_o=1 only in this state.
- pready_o stays 0 outside RESP, so an APB transfer arriving during CLEAR or ACC/RD is stalled and accepted on the next IDLE.
- prdata_o holds its last read value. It is unchanged by writes, errors and clears.
- Errors never assert bram_wea_o.

## Timing
- T0 is the cycle psel_i is first seen in IDLE with no clear pending.
- Write: bram_wea_o high in T1; pready_o in T2 (one wait state on a standard setup/access sequence).
- Read: address at BRAM in T1, data captured at the end of T2, pready_o and prdata_o in T3.
- Error: pready_o=1 and pslverr_o=1 in T2.
- Clear: exactly 2**ADDR_WIDTH cycles with busy=1. For the defaults, 16 cycles, addresses 0..15.
- A back-to-back APB setup in the cycle after RESP is accepted in that cycle (IDLE).
- Port-A write and scanout read of the same address on port B: port B returns old or new data per BRAM behaviour. No hazard handling is done here.

## Test plan
- Write 0xA5 to paddr 0x8: wea=1, addr=2, din=0xA5 in T1 only; pready=1, pslverr=0 in T2. Read of 0x8 then returns prdata=0x000000A5 with pready in T3.
- paddr 0x41 (misaligned) and 0x40 (out of range, ADDR_WIDTH=4): pready=1, pslverr=1 in T2; wea never 1; prdata unchanged.
- 1-cycle clear_req_i pulse in IDLE with CLEAR_VALUE=0x20: busy=1 for 16 cycles, wea=1, addr 0..15, din 0x20. Reads of all 16 words then return 0x20.
- Write 0x5A to word 3 issued in clear cycle 4: pready held 0 until busy falls, then wea=1 in the next cycle and pready one cycle later. A read of word 3 returns 0x5A, not 0x20.
- Two arbitration cases:
  - psel_i and clear_req_i together in IDLE: clear runs first, then the APB transfer completes.
  - clear_req_i during ACC of a read: the read completes with correct data, then the clear starts.
- rst_ni low while CLEAR is at address 7: busy, wea, pready, prdata and addr go to 0 immediately. After release the state is IDLE and no clear restarts.
